// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: drives a word-addressed data bus with a req/ready handshake,
// stalls the pipeline while the access is in flight and returns the extended load result.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        lsu_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam logic [15:0] LP_TMO = 16'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_func3;
    logic [1:0]  r_off;
    logic [15:0] r_cnt;

    logic        w_start;
    logic        w_legal;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_ext;
    logic [15:0] w_cnt_nxt;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_start   = mem_valid & (mem_read | mem_write);
    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_timeout = (LP_TMO != 16'd0) && (w_cnt_nxt == LP_TMO);

    always_comb begin
        w_legal = 1'b1;
        case (func3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~addr[0];
            3'b010:  w_legal = (addr[1:0] == 2'b00);
            3'b100:  w_legal = ~mem_write;
            3'b101:  w_legal = ~mem_write & ~addr[0];
            default: w_legal = 1'b0;
        endcase
        if (mem_read & mem_write) begin
            w_legal = 1'b0;
        end
    end

    // Store data is replicated across all lanes; byte enables select the target lane.
    always_comb begin
        w_wdata = '0;
        w_be    = '0;
        if (mem_write) begin
            case (func3[1:0])
                2'b00: begin
                    w_wdata = {4{store_data[7:0]}};
                    w_be    = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    w_wdata = {2{store_data[15:0]}};
                    w_be    = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = store_data;
                    w_be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = dmem_rdata[8*r_off +: 8];
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_func3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        lsu_stall   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start && w_legal) begin
                    lsu_stall   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                lsu_stall = 1'b1;
                if (dmem_ready || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_func3    <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            lsu_done   <= 1'b0;
            lsu_err    <= 1'b0;
            load_data  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_legal) begin
                            r_func3    <= func3;
                            r_off      <= addr[1:0];
                            r_cnt      <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_wdata <= w_wdata;
                            dmem_be    <= w_be;
                        end else begin
                            lsu_err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        lsu_done <= 1'b1;
                        if (!dmem_we) begin
                            load_data <= w_ext;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_timeout) begin
                            dmem_req  <= 1'b0;
                            lsu_err   <= 1'b1;
                            load_data <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (watchdog set to 4 REQ cycles).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [31:0] load_data;

    int n_chk = 0;
    int n_bad = 0;

    int a_req, a_stall, a_done_c, a_err_c, a_ndone, a_nerr, a_unstable;
    logic [31:0] a_ld, a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        a_we;
    int n_after;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .func3(func3), .addr(addr), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .load_data(load_data), .lsu_err(lsu_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one access for a fixed 12-cycle window; ready_at = REQ cycle (1-based) with ready, 0 = never.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int ready_at);
        logic snap_ok;
        a_req = 0; a_stall = 0; a_done_c = -1; a_err_c = -1;
        a_ndone = 0; a_nerr = 0; a_unstable = 0; a_ld = '0;
        a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        snap_ok = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_read = rd; mem_write = wr; func3 = f3;
        addr = a; store_data = sd; dmem_ready = 1'b0; dmem_rdata = rdat;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (lsu_stall) a_stall++;
            if (dmem_req) begin
                a_req++;
                if (!snap_ok) begin
                    snap_ok = 1'b1;
                    a_we = dmem_we; a_addr = dmem_addr; a_wdata = dmem_wdata; a_be = dmem_be;
                end else if ({a_we, a_addr, a_wdata, a_be} !== {dmem_we, dmem_addr, dmem_wdata, dmem_be}) begin
                    a_unstable++;
                end
            end
            if (lsu_done) begin a_ndone++; a_done_c = c; a_ld = load_data; end
            if (lsu_err)  begin a_nerr++;  a_err_c  = c; a_ld = load_data; end
            dmem_ready = dmem_req && (a_req == ready_at);
            if (c > 0 && !lsu_stall) mem_valid = 1'b0;
        end
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic chk_illegal(input string tag);
        chk({tag, "_req"},   32'(a_req),   32'd0);
        chk({tag, "_stall"}, 32'(a_stall), 32'd0);
        chk({tag, "_errc"},  32'(a_err_c), 32'd1);
        chk({tag, "_nerr"},  32'(a_nerr),  32'd1);
        chk({tag, "_ndone"}, 32'(a_ndone), 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        func3 = '0; addr = '0; store_data = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
        chk("rst_done",  {31'd0, lsu_done}, 32'd0);
        chk("rst_err",   {31'd0, lsu_err}, 32'd0);
        chk("rst_ld",    load_data, 32'd0);
        chk("rst_bus",   {dmem_addr[27:0], dmem_be}, 32'd0);

        // SB, ready on first REQ cycle
        access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1);
        chk("sb_req",   32'(a_req), 32'd1);
        chk("sb_stall", 32'(a_stall), 32'd2);
        chk("sb_donec", 32'(a_done_c), 32'd2);
        chk("sb_we",    {31'd0, a_we}, 32'd1);
        chk("sb_addr",  a_addr, 32'h0000_1000);
        chk("sb_be",    {28'd0, a_be}, 32'h8);
        chk("sb_wdata", a_wdata, 32'hA5A5_A5A5);
        chk("sb_nerr",  32'(a_nerr), 32'd0);

        access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        chk("lh_ld",   a_ld, 32'hFFFF_8001);
        chk("lh_addr", a_addr, 32'h0000_2000);
        chk("lh_be",   {28'd0, a_be}, 32'h0);
        chk("lh_we",   {31'd0, a_we}, 32'd0);
        access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        chk("lhu_ld", a_ld, 32'h0000_8001);
        access(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h8001_1234, 1);
        chk("lb1_ld", a_ld, 32'h0000_0012);
        access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8001_1234, 2);
        chk("lb3_ld",    a_ld, 32'hFFFF_FF80);
        chk("lb3_donec", 32'(a_done_c), 32'd3);

        access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 1);
        chk("sh_be",    {28'd0, a_be}, 32'hC);
        chk("sh_wdata", a_wdata, 32'hBEEF_BEEF);
        chk("sh_ndone", 32'(a_ndone), 32'd1);
        chk("sh_ldkeep", load_data, 32'hFFFF_FF80);

        access(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'h0, 1);
        chk_illegal("ill_mis");
        access(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 1);
        chk_illegal("ill_f3");
        access(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 1);
        chk_illegal("ill_rw");
        access(1'b0, 1'b1, 3'b101, 32'h0000_1000, 32'h0, 32'h0, 1);
        chk_illegal("ill_shu");

        access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 3);
        chk("lw_req",      32'(a_req), 32'd3);
        chk("lw_stall",    32'(a_stall), 32'd4);
        chk("lw_donec",    32'(a_done_c), 32'd4);
        chk("lw_ld",       a_ld, 32'hDEAD_BEEF);
        chk("lw_unstable", 32'(a_unstable), 32'd0);

        access(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 32'h1111_2222, 0);
        chk("to_req",   32'(a_req), 32'd4);
        chk("to_stall", 32'(a_stall), 32'd5);
        chk("to_errc",  32'(a_err_c), 32'd5);
        chk("to_nerr",  32'(a_nerr), 32'd1);
        chk("to_ndone", 32'(a_ndone), 32'd0);
        chk("to_ld",    a_ld, 32'd0);

        // reset during the second REQ cycle
        @(negedge clk);
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
        addr = 32'h0000_3000; dmem_ready = 1'b0; dmem_rdata = 32'h5555_AAAA;
        dmem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rr_req_pre", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rr_req",   {31'd0, dmem_req}, 32'd0);
        chk("rr_stall", {31'd0, lsu_stall}, 32'd0);
        chk("rr_addr",  dmem_addr, 32'd0);
        chk("rr_ld",    load_data, 32'd0);
        n_after = 0;
        for (int c = 0; c < 4; c++) begin
            if (lsu_done || lsu_err || dmem_req) n_after++;
            dmem_ready = 1'b1;
            @(negedge clk);
            #1;
        end
        dmem_ready = 1'b0;
        chk("rr_quiet", 32'(n_after), 32'd0);

        access(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 2);
        chk("sw_req",    32'(a_req), 32'd2);
        chk("sw_donec",  32'(a_done_c), 32'd3);
        chk("sw_addr",   a_addr, 32'h0000_0010);
        chk("sw_be",     {28'd0, a_be}, 32'hF);
        chk("sw_wdata",  a_wdata, 32'hCAFE_F00D);
        chk("sw_ldkeep", load_data, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
